// File: rtl/ad9361_spi_pkg.sv
// rtl/ad9361_spi_pkg.sv - shared instruction fields, ID address and FSM encoding for the AD9361 SPI responder
// Contents:
//   W_BIT, NB_MSB, NB_LSB, ADDR_MSB : bit positions inside the 16-bit instruction word
//   ID_ADDR                         : read-only product ID register address
//   state_t                         : responder FSM states
package ad9361_spi_pkg;

  localparam int W_BIT    = 15;
  localparam int NB_MSB   = 14;
  localparam int NB_LSB   = 12;
  localparam int ADDR_MSB = 9;

  localparam logic [9:0] ID_ADDR = 10'h037;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with registered history for rise/fall pulse detection
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized 0->1 / 1->0 transitions
// STAGES must be at least 1; RESET_VAL is the idle level of the input.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
      hist <= RESET_VAL;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/ad9361_spi_responder.sv
// rtl/ad9361_spi_responder.sv - oversampled SPI slave emulating the AD9361 register port
// Ports:
//   clk, rst_n                  : system clock (>= 8x spi_clk), asynchronous active-low reset
//   spi_clk, spi_enb, spi_di    : SPI bus from the master (clock idles low, enable active low)
//   spi_do                      : read data to the master, 0 outside read data phases
//   wr_valid, wr_addr, wr_data  : one-cycle snoop of every committed write byte
//   txn_done, txn_abort         : one-cycle pulse on enable release after a complete / partial transaction
module ad9361_spi_responder
  import ad9361_spi_pkg::*;
#(
  parameter int         REG_DEPTH   = 64,
  parameter logic [7:0] PRODUCT_ID  = 8'h0A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_enb,
  input  logic       spi_di,
  output logic       spi_do,
  output logic       wr_valid,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       txn_done,
  output logic       txn_abort
);

  localparam int          AW      = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [10:0] DEPTH_L = 11'(REG_DEPTH);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic enb_lvl, enb_rise, enb_fall;
  logic di_lvl, di_rise, di_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .din(spi_clk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_enb (
    .clk(clk), .rst_n(rst_n), .din(spi_enb), .level(enb_lvl), .rise(enb_rise), .fall(enb_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_di (
    .clk(clk), .rst_n(rst_n), .din(spi_di), .level(di_lvl), .rise(di_rise), .fall(di_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, enb_lvl, di_rise, di_fall};

  state_t      state, state_next;
  logic [14:0] shift_in;     // the 16th bit is always taken straight from di_lvl
  logic [3:0]  bit_cnt;
  logic        is_write;
  logic [2:0]  nb;
  logic [2:0]  byte_cnt;
  logic [9:0]  addr;
  logic [7:0]  shift_out;
  logic [7:0]  mem [REG_DEPTH];

  logic start, latch, byte_end, done_p, abort_p, sample, drive, mem_we;
  logic [9:0] instr_addr;
  logic [7:0] rx_byte;

  assign instr_addr = {shift_in[ADDR_MSB-1:0], di_lvl};
  assign rx_byte    = {shift_in[6:0], di_lvl};

  function automatic logic in_range(input logic [9:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic [7:0] rd(input logic [9:0] a);
    if (a == ID_ADDR)  return PRODUCT_ID;
    else if (in_range(a)) return mem[a[AW-1:0]];
    else return 8'h00;
  endfunction

  // Enable release takes priority over any clock edge seen in the same cycle.
  assign sample = sclk_rise && !enb_rise && (state == INSTR || state == DATA);
  assign drive  = sclk_fall && !enb_rise && state == DATA && !is_write;
  assign mem_we = byte_end && is_write && in_range(addr) && (addr != ID_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    latch      = 1'b0;
    byte_end   = 1'b0;
    done_p     = 1'b0;
    abort_p    = 1'b0;
    if (enb_rise) begin
      state_next = IDLE;
      done_p     = (state == HOLD);
      abort_p    = (state == INSTR) || (state == DATA);
    end else begin
      case (state)
        IDLE:  if (enb_fall) begin
                 state_next = INSTR;
                 start      = 1'b1;
               end
        INSTR: if (sclk_rise && bit_cnt == 4'd15) begin
                 state_next = DATA;
                 latch      = 1'b1;
               end
        DATA:  if (sclk_rise && bit_cnt[2:0] == 3'd7) begin
                 byte_end = 1'b1;
                 if (byte_cnt == nb) state_next = HOLD;
               end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_in  <= '0;
      bit_cnt   <= '0;
      is_write  <= 1'b0;
      nb        <= '0;
      byte_cnt  <= '0;
      addr      <= '0;
      shift_out <= '0;
      spi_do    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      txn_done  <= 1'b0;
      txn_abort <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      txn_done  <= done_p;
      txn_abort <= abort_p;
      if (sample) begin
        shift_in <= {shift_in[13:0], di_lvl};
        bit_cnt  <= bit_cnt + 4'd1;  // wraps 15 -> 0 on the instruction's last bit
      end
      if (start) bit_cnt <= '0;
      if (latch) begin
        is_write <= shift_in[W_BIT-1];
        nb       <= shift_in[NB_MSB-1:NB_LSB-1];
        addr     <= instr_addr;
        byte_cnt <= '0;
        if (!shift_in[W_BIT-1]) shift_out <= rd(instr_addr);
      end
      if (byte_end) begin
        byte_cnt <= byte_cnt + 3'd1;
        addr     <= addr - 10'd1;
        if (is_write) begin
          wr_valid <= 1'b1;
          wr_addr  <= addr;
          wr_data  <= rx_byte;
        end else begin
          shift_out <= rd(addr - 10'd1);
        end
      end
      if (drive) begin
        spi_do    <= shift_out[7];
        shift_out <= {shift_out[6:0], 1'b0};
      end else if (state != DATA || is_write) begin
        spi_do <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[addr[AW-1:0]] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_ad9361_spi_responder.sv
// tb/tb_ad9361_spi_responder.sv - directed self-checking bench for the AD9361 SPI responder
// Ports: none (top-level bench)
module tb_ad9361_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_clk;
  logic       spi_enb;
  logic       spi_di;
  logic       spi_do;
  logic       wr_valid;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       txn_done;
  logic       txn_abort;

  ad9361_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_enb(spi_enb), .spi_di(spi_di),
    .spi_do(spi_do), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .txn_done(txn_done), .txn_abort(txn_abort));

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         done_n  = 0;
  int         abort_n = 0;
  logic       rx_bit;
  logic [7:0] rb;
  int         base, d0, a0;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_a.push_back(wr_addr);
      wr_d.push_back(wr_data);
    end
    if (txn_done)  done_n++;
    if (txn_abort) abort_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    spi_di = b;
    tick(8);
    rx_bit  = spi_do;
    spi_clk = 1'b1;
    tick(8);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i]);
      rb[i] = rx_bit;
    end
  endtask

  task automatic spi_start();
    spi_enb = 1'b0;
    tick(8);
  endtask

  task automatic spi_stop();
    tick(8);
    spi_enb = 1'b1;
    tick(12);
  endtask

  initial begin
    rst_n   = 1'b0;
    spi_clk = 1'b0;
    spi_enb = 1'b1;
    spi_di  = 1'b0;
    tick(3);
    chk("reset_outputs", 32'({spi_do, wr_valid, wr_addr, wr_data, txn_done, txn_abort}), 32'h0);
    rst_n = 1'b1;
    tick(5);

    // Single-byte write 0x8005 <- A5
    d0 = done_n;
    spi_start(); spi_byte(8'h80); spi_byte(8'h05); spi_byte(8'hA5); spi_stop();
    chk("t1_wr_count", 32'(wr_a.size()), 32'd1);
    chk("t1_wr_addr", 32'(wr_a[0]), 32'h005);
    chk("t1_wr_data", 32'(wr_d[0]), 32'hA5);
    chk("t1_done", 32'(done_n), 32'(d0 + 1));
    chk("t1_no_abort", 32'(abort_n), 32'd0);

    // Read back 0x0005
    spi_start(); spi_byte(8'h00); spi_byte(8'h05); spi_byte(8'h00); spi_stop();
    chk("t2_rd", 32'(rb), 32'hA5);
    chk("t2_no_wr", 32'(wr_a.size()), 32'd1);

    // Three-byte descending write 0xA012 then read 0x2012
    base = wr_a.size();
    spi_start(); spi_byte(8'hA0); spi_byte(8'h12);
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_stop();
    chk("t3_wr_count", 32'(wr_a.size()), 32'(base + 3));
    chk("t3_a0", 32'({wr_a[base], wr_d[base]}), 32'h01211);
    chk("t3_a1", 32'({wr_a[base+1], wr_d[base+1]}), 32'h01122);
    chk("t3_a2", 32'({wr_a[base+2], wr_d[base+2]}), 32'h01033);
    spi_start(); spi_byte(8'h20); spi_byte(8'h12);
    spi_byte(8'h00); chk("t3_rd0", 32'(rb), 32'h11);
    spi_byte(8'h00); chk("t3_rd1", 32'(rb), 32'h22);
    spi_byte(8'h00); chk("t3_rd2", 32'(rb), 32'h33);
    spi_stop();

    // Product ID is read-only but writes still snoop
    spi_start(); spi_byte(8'h00); spi_byte(8'h37); spi_byte(8'h00); spi_stop();
    chk("t4_id", 32'(rb), 32'h0A);
    base = wr_a.size();
    spi_start(); spi_byte(8'h80); spi_byte(8'h37); spi_byte(8'hFF); spi_stop();
    chk("t4_snoop", 32'({wr_a[base], wr_d[base]}), 32'h037FF);
    spi_start(); spi_byte(8'h00); spi_byte(8'h37); spi_byte(8'h00); spi_stop();
    chk("t4_id_again", 32'(rb), 32'h0A);

    // Extra clocks in HOLD are ignored: no extra write, spi_do low
    base = wr_a.size();
    spi_start(); spi_byte(8'h80); spi_byte(8'h06); spi_byte(8'h77); spi_byte(8'h99); spi_stop();
    chk("t5_hold_wr_count", 32'(wr_a.size()), 32'(base + 1));
    chk("t5_hold_wr", 32'({wr_a[base], wr_d[base]}), 32'h00677);
    spi_start(); spi_byte(8'h00); spi_byte(8'h06);
    spi_byte(8'h00); chk("t5_rd", 32'(rb), 32'h77);
    spi_byte(8'h00); chk("t5_hold_do", 32'(rb), 32'h00);
    spi_stop();

    // Abort after one full byte plus a partial one
    base = wr_a.size(); d0 = done_n; a0 = abort_n;
    spi_start(); spi_byte(8'h91); spi_byte(8'h20); spi_byte(8'hAB);
    spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b0); spi_stop();
    chk("t6_wr_count", 32'(wr_a.size()), 32'(base + 1));
    chk("t6_wr", 32'({wr_a[base], wr_d[base]}), 32'h120AB);
    chk("t6_abort", 32'(abort_n), 32'(a0 + 1));
    chk("t6_no_done", 32'(done_n), 32'(d0));
    spi_start(); spi_byte(8'h90); spi_byte(8'h08); spi_byte(8'hAB);
    spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b0); spi_stop();
    spi_start(); spi_byte(8'h10); spi_byte(8'h08);
    spi_byte(8'h00); chk("t6_rd_kept", 32'(rb), 32'hAB);
    spi_byte(8'h00); chk("t6_rd_partial", 32'(rb), 32'h00);
    spi_stop();

    // Address wrap 0x000 -> 0x3FF (out of range reads 0)
    spi_start(); spi_byte(8'h80); spi_byte(8'h00); spi_byte(8'h5A); spi_stop();
    spi_start(); spi_byte(8'h10); spi_byte(8'h00);
    spi_byte(8'h00); chk("t7_rd0", 32'(rb), 32'h5A);
    spi_byte(8'h00); chk("t7_wrap", 32'(rb), 32'h00);
    spi_stop();

    // Reset mid-transaction
    d0 = done_n; a0 = abort_n;
    spi_start(); spi_byte(8'h00); spi_byte(8'h05); spi_bit(1'b0); spi_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_outputs", 32'({spi_do, wr_valid, wr_addr, wr_data, txn_done, txn_abort}), 32'h0);
    spi_enb = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("t8_no_done", 32'(done_n), 32'(d0));
    chk("t8_no_abort", 32'(abort_n), 32'(a0));
    spi_start(); spi_byte(8'h00); spi_byte(8'h05); spi_byte(8'h00); spi_stop();
    chk("t8_mem5_cleared", 32'(rb), 32'h00);
    spi_start(); spi_byte(8'h00); spi_byte(8'h06); spi_byte(8'h00); spi_stop();
    chk("t8_mem6_cleared", 32'(rb), 32'h00);
    chk("t8_done_after", 32'(done_n), 32'(d0 + 2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
